data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the core's data bus: the slave that services load/store requests issued through the data bus controller (wd/rd, size, address, write data).
- Implements a word-organised RAM with byte/half/word access, configurable wait states, a ready/busy handshake and fault signalling for bad accesses.
- Sits beside the program memory as the Harvard data-side store, mapped at BASE_ADDR.

Parameters:
- DATA_ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_2000, byte address of word 0; must be 4-byte aligned.
- WAIT_STATES, 1, extra busy cycles inserted between acceptance and response (0..15).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wd  in  1  write request.
- rd  in  1  read request.
- size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- addr  in  32  byte address of the access.
- data_in  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- data_out  out  32  load data, right-aligned and zero-extended (sign extension is the core's job).
- ready  out  1  responder initialised and able to accept requests.
- busy  out  1  request in progress; core must stall.
- fault  out  1  one-cycle pulse: the completing access was rejected.

Behaviour:
- Reset (rst=0, async): state=INIT, ready=0, busy=0, fault=0, data_out=0, latched request cleared. An in-flight write is dropped and memory is not written.
- States: INIT, IDLE, WAIT, RESP.
- INIT -> IDLE: transitions one cycle after reset release. ready=1 from IDLE onward.
- Acceptance: in IDLE with ready=1 and (wd|rd)=1, latch addr, size_in, data_in, wd and rd on the edge.
  - WAIT_STATES>0: next state WAIT, wait counter loaded with WAIT_STATES-1.
  - WAIT_STATES=0: next state RESP.
- busy is combinational: 1 in IDLE when a request is presented and ready=1, and 1 throughout WAIT; 0 in INIT, RESP, and in IDLE with no request. The core therefore stalls in the request cycle itself.
- WAIT: counter decrements each cycle; at 0, next state RESP.
- Entering RESP:
  - Writes are committed to the RAM.
  - Read data is registered into data_out.
  - fault is registered.
- RESP: lasts exactly one cycle with busy=0; the core advances in this cycle. Next state is always IDLE; requests presented during RESP are ignored.
- Total latency from acceptance edge to RESP: WAIT_STATES+1 cycles.
- Fault conditions, evaluated on latched values (any one is enough):
  - size 11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^DATA_ADDR_WIDTH;
  - wd and rd both 1.
  A faulting access writes nothing, drives data_out=0 and asserts fault for the RESP cycle only.
- Word index = (addr - BASE_ADDR) >> 2; lane = addr[1:0].
- Write lanes:
  - byte: data_in[7:0] written to lane addr[1:0];
  - half: data_in[15:0] written to lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes written.
  Unselected lanes keep their contents.
- Read: the selected byte/half is shifted to bit 0; upper bits are 0.
- data_out holds its value until the next read or faulting access completes; writes leave it unchanged.

Optional Feature:
- MEM_CLEAR_ON_RESET_EN defined:
  - INIT holds ready=0 and walks a clear counter from word 0 to word 2^DATA_ADDR_WIDTH-1, writing 0 to one word per cycle.
  - INIT -> IDLE after the last word is cleared, i.e. 2^DATA_ADDR_WIDTH cycles after reset release.
  - If reset is asserted mid-clear, the counter restarts from 0.
- Not defined: memory contents survive reset and INIT lasts one cycle.

Test Plan:
- Reset release, WAIT_STATES=1 -> ready=0 for 1 cycle then 1. With MEM_CLEAR_ON_RESET_EN, ready rises after 1024 cycles and a subsequent word read of every address returns 0.
- Word write 32'hDEADBEEF @ 0x2000, then word read @ 0x2000 -> busy high for 2 cycles (request cycle + WAIT); RESP data_out=32'hDEADBEEF; fault=0.
- Byte write 8'hA5 @ 0x2003 over 32'h11223344, then word read -> 32'hA5223344; byte read @ 0x2003 -> 32'h000000A5; half read @ 0x2002 -> 32'h0000A522.
- Misaligned word read @ 0x2002, half write @ 0x2001, size 11, addr 0x1FFC, addr 0x3000 -> each gives fault=1 for exactly one cycle and data_out=0; memory unchanged on re-read.
- rst pulled low during WAIT of a word write 32'h12345678 @ 0x2010 -> busy drops immediately; after reinit, a read @ 0x2010 returns the prior value (0 or the old contents), not 32'h12345678.
- WAIT_STATES=0, back-to-back reads @ 0x2000 and 0x2004 -> each completes one cycle after acceptance; the request presented during RESP is not accepted until the following IDLE cycle.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: data-side RAM slave with byte/half/word access, wait states and fault reporting.
// Defining MEM_CLEAR_ON_RESET_EN zeroes every word during INIT before ready rises.
module data_memory_responder #(
    parameter int          DATA_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
    parameter int          WAIT_STATES     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size_in,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        fault
);
    localparam int         DEPTH     = 1 << DATA_ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
    state_t state, next;

    logic [31:0] mem [DEPTH];
    logic [31:0] l_addr, l_data;
    logic [1:0]  l_size;
    logic        l_wd, l_rd;
    logic [3:0]  cnt;
    logic        accept, enter_resp, clr_done;
    logic [31:0] r_addr, r_data, off, rword, rd_val, wdata;
    logic [1:0]  r_size, lane;
    logic        r_wd, r_rd, r_fault;
    logic [3:0]  be;
    logic [DATA_ADDR_WIDTH-1:0] idx;

    assign accept     = (state == IDLE) && (wd || rd);
    assign enter_resp = (next == RESP);
    assign ready      = (state != INIT);
    assign busy       = accept || (state == WAIT);

    // With zero wait states the access completes on its own acceptance edge, so use the live request.
    assign r_addr = accept ? addr    : l_addr;
    assign r_data = accept ? data_in : l_data;
    assign r_size = accept ? size_in : l_size;
    assign r_wd   = accept ? wd      : l_wd;
    assign r_rd   = accept ? rd      : l_rd;

    assign off     = r_addr - BASE_ADDR;
    assign lane    = off[1:0];
    assign idx     = off[DATA_ADDR_WIDTH+1:2];
    assign r_fault = (r_size == 2'b11) || (r_size == 2'b01 && lane[0]) ||
                     (r_size == 2'b10 && lane != 2'b00) || (r_addr < BASE_ADDR) ||
                     (|off[31:DATA_ADDR_WIDTH+2]) || (r_wd && r_rd);

    assign rword  = mem[idx] >> {lane, 3'b000};
    assign rd_val = r_size == 2'b00 ? {24'h0, rword[7:0]} :
                    r_size == 2'b01 ? {16'h0, rword[15:0]} : rword;
    assign be     = r_size == 2'b00 ? 4'b0001 << lane :
                    r_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata  = r_size == 2'b00 ? {4{r_data[7:0]}} :
                    r_size == 2'b01 ? {2{r_data[15:0]}} : r_data;

    always_comb begin
        next = state;
        case (state)
            INIT:    next = clr_done ? IDLE : INIT;
            IDLE:    next = accept ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE;
            WAIT:    next = (cnt == 4'd0) ? RESP : WAIT;
            default: next = IDLE;
        endcase
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    logic [DATA_ADDR_WIDTH-1:0] clr_cnt;
    assign clr_done = &clr_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clr_cnt <= '0;
        else if (state == INIT)
            clr_cnt <= clr_cnt + 1'b1;
    end
`else
    assign clr_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_ON_RESET_EN
        if (state == INIT)
            mem[clr_cnt] <= '0;
`endif
        if (enter_resp && r_wd && !r_fault)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            cnt      <= '0;
            l_addr   <= '0;
            l_data   <= '0;
            l_size   <= '0;
            l_wd     <= 1'b0;
            l_rd     <= 1'b0;
            data_out <= '0;
            fault    <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                l_addr <= addr;
                l_data <= data_in;
                l_size <= size_in;
                l_wd   <= wd;
                l_rd   <= rd;
                cnt    <= WAIT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            fault <= enter_resp && r_fault;
            if (enter_resp && (r_fault || r_rd))
                data_out <= r_fault ? 32'h0 : rd_val;
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: two responders (one and zero wait states) checked against a byte-array model.
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wd_a [2], rd_a [2], ready_a [2], busy_a [2], fault_a [2];
    logic [1:0]  sz_a [2];
    logic [31:0] addr_a [2], din_a [2], dout_a [2];
    logic [7:0]  mb [2][4096];
    logic [31:0] exp_dout [2];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_memory_responder #(.WAIT_STATES(g == 0 ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst), .wd(wd_a[g]), .rd(rd_a[g]), .size_in(sz_a[g]),
            .addr(addr_a[g]), .data_in(din_a[g]), .data_out(dout_a[g]),
            .ready(ready_a[g]), .busy(busy_a[g]), .fault(fault_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic bad(input logic w, input logic r, input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
               a < 32'h2000 || a >= 32'h3000 || (w && r);
    endfunction

    function automatic logic [31:0] mword(input int d, input logic [31:0] a);
        logic [31:0] v = 0;
        for (int k = 0; k < 4; k++)
            v |= 32'(mb[d][a - 32'h2000 + k]) << (8 * k);
        return v;
    endfunction

    task automatic access(input int d, input logic w, input logic r, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] dat);
        int n = 0;
        int nb;
        logic f;
        logic [31:0] v = 0;
        @(negedge clk);
        wd_a[d] = w; rd_a[d] = r; sz_a[d] = sz; addr_a[d] = a; din_a[d] = dat;
        #1 check("busy_req", 32'(busy_a[d]), 1);
        @(posedge clk); #1;
        wd_a[d] = 0; rd_a[d] = 0;
        while (busy_a[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, d == 0 ? 1 : 0);
        f  = bad(w, r, sz, a);
        nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        if (!f)
            for (int k = 0; k < nb; k++) begin
                if (w) mb[d][a - 32'h2000 + k] = dat[8*k +: 8];
                v |= 32'(mb[d][a - 32'h2000 + k]) << (8 * k);
            end
        if (f) exp_dout[d] = 0;
        else if (r) exp_dout[d] = v;
        check("fault", 32'(fault_a[d]), 32'(f));
        check("data_out", dout_a[d], exp_dout[d]);
        @(posedge clk); #1 check("fault_pulse", 32'(fault_a[d]), 0);
    endtask

    initial begin
        int d, op;
        logic [1:0] sz;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            wd_a[i] = 0; rd_a[i] = 0; sz_a[i] = 0; addr_a[i] = 0; din_a[i] = 0; exp_dout[i] = 0;
        end
        rd_a[0] = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready_a[i]), 0);
            check("rst_busy", 32'(busy_a[i]), 0);
            check("rst_fault", 32'(fault_a[i]), 0);
            check("rst_dout", dout_a[i], 0);
        end
        rd_a[0] = 0;
        @(negedge clk) rst = 1;
        #1 check("init_ready", 32'(ready_a[0]), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) check("ready_up", 32'(ready_a[i]), 1);

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 1024; w++)
                access(i, 1, 0, 2'b10, 32'h2000 + 4 * w, $urandom);

        access(0, 1, 0, 2'b10, 32'h2000, 32'hDEADBEEF);
        access(0, 0, 1, 2'b10, 32'h2000, 0);
        check("dir_deadbeef", dout_a[0], 32'hDEADBEEF);
        access(0, 1, 0, 2'b10, 32'h2000, 32'h11223344);
        access(0, 1, 0, 2'b00, 32'h2003, 32'h000000A5);
        access(0, 0, 1, 2'b10, 32'h2000, 0);
        check("dir_merge", dout_a[0], 32'hA5223344);
        access(0, 0, 1, 2'b00, 32'h2003, 0);
        check("dir_byte", dout_a[0], 32'h000000A5);
        access(0, 0, 1, 2'b01, 32'h2002, 0);
        check("dir_half", dout_a[0], 32'h0000A522);
        access(0, 0, 1, 2'b10, 32'h2002, 0);
        access(0, 1, 0, 2'b01, 32'h2001, 32'hFFFF);
        access(0, 0, 1, 2'b11, 32'h2000, 0);
        access(0, 0, 1, 2'b10, 32'h1FFC, 0);
        access(0, 0, 1, 2'b10, 32'h3000, 0);
        access(0, 1, 1, 2'b10, 32'h2000, 32'h0BADF00D);
        access(0, 0, 1, 2'b10, 32'h2000, 0);
        check("dir_unchanged", dout_a[0], 32'hA5223344);

        @(negedge clk);
        wd_a[0] = 1; sz_a[0] = 2'b10; addr_a[0] = 32'h2010; din_a[0] = 32'h12345678;
        @(posedge clk); #1 check("busy_wait", 32'(busy_a[0]), 1);
        rst = 0;
        #1 check("busy_drop", 32'(busy_a[0]), 0);
        check("ready_drop", 32'(ready_a[0]), 0);
        wd_a[0] = 0;
        exp_dout[0] = 0; exp_dout[1] = 0;
        check("dout_rst", dout_a[0], 0);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        access(0, 0, 1, 2'b10, 32'h2010, 0);

        access(1, 1, 0, 2'b10, 32'h2000, 32'hCAFE0001);
        access(1, 1, 0, 2'b10, 32'h2004, 32'hCAFE0002);
        @(negedge clk);
        rd_a[1] = 1; sz_a[1] = 2'b10; addr_a[1] = 32'h2000;
        #1 check("b2b_busy", 32'(busy_a[1]), 1);
        @(posedge clk); #1;
        check("b2b_resp_busy", 32'(busy_a[1]), 0);
        check("b2b_first", dout_a[1], mword(1, 32'h2000));
        addr_a[1] = 32'h2004;
        #1 check("resp_ignore", 32'(busy_a[1]), 0);
        @(posedge clk); #1;
        check("idle_accept", 32'(busy_a[1]), 1);
        check("b2b_hold", dout_a[1], mword(1, 32'h2000));
        @(posedge clk); #1;
        check("b2b_second", dout_a[1], mword(1, 32'h2004));
        exp_dout[1] = mword(1, 32'h2004);
        rd_a[1] = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 400; i++) begin
            d  = $urandom_range(0, 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'h2000 + $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0)
                a &= (sz == 2'b10) ? ~32'h3 : (sz == 2'b01) ? ~32'h1 : ~32'h0;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            op = $urandom_range(0, 9);
            access(d, op < 5 || op == 9, op >= 5, sz, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
